// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM assignment engine: streams in an NxN cost table,
// serves zero-latency lookups and captures the first result. Optional macro: JAM_LOOKUP_CNT_EN.
module jam_cost_server #(
    parameter int N      = 8,
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              reload,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    output logic              table_ready,
    output logic              jam_hold,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic              result_done,
    output logic [9:0]        result_min_cost,
    output logic [3:0]        result_match_count
`ifdef JAM_LOOKUP_CNT_EN
    ,
    output logic [15:0]       lookup_cnt
`endif
);

    typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

    localparam logic [5:0] LAST_IDX = 6'(N * N - 1);

    state_t            state, next_state;
    logic [5:0]        idx;
    logic [5:0]        rd_addr;
    logic              load_fire;
    logic [COST_W-1:0] cost_table [64];

    // A reload in the same cycle as load_valid drops the entry.
    assign load_fire = (state == LOAD) && load_valid && !reload;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (reload) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD:    if (load_valid && idx == LAST_IDX) next_state = SERVE;
                SERVE:   if (Valid) next_state = DONE;
                DONE:    next_state = DONE;
                default: next_state = LOAD;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx <= '0;
        end else if (reload) begin
            idx <= '0;
        end else if (load_fire) begin
            idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) cost_table[i] <= '0;
        end else if (load_fire) begin
            cost_table[idx] <= load_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_done        <= 1'b0;
            result_min_cost    <= '0;
            result_match_count <= '0;
        end else if (reload) begin
            result_done        <= 1'b0;
            result_min_cost    <= '0;
            result_match_count <= '0;
        end else if (state == SERVE && Valid) begin
            result_done        <= 1'b1;
            result_min_cost    <= MinCost;
            result_match_count <= MatchCount;
        end
    end

`ifdef JAM_LOOKUP_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookup_cnt <= '0;
        end else if (reload) begin
            lookup_cnt <= '0;
        end else if (state == SERVE && lookup_cnt != 16'hFFFF) begin
            lookup_cnt <= lookup_cnt + 16'd1;
        end
    end
`endif

    assign load_ready  = (state == LOAD);
    assign table_ready = (state == SERVE) || (state == DONE);
    assign jam_hold    = (state == LOAD);

    // Lookup is state-independent so the engine sees zeros before the table is loaded.
    assign rd_addr = 6'(int'(W) * N + int'(J));

    always_comb begin
        Cost = '0;
        if (int'(W) < N && int'(J) < N) Cost = cost_table[rd_addr];
    end

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized self-checking bench for jam_cost_server against a behavioural table/result model.
// Define JAM_LOOKUP_CNT_EN for both files to also check the lookup counter.
module tb_jam_cost_server;

    localparam int N      = 8;
    localparam int COST_W = 7;

    logic              CLK = 1'b0;
    logic              RST;
    logic              reload;
    logic              load_valid;
    logic [COST_W-1:0] load_data;
    logic              load_ready;
    logic              table_ready;
    logic              jam_hold;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;
    logic              result_done;
    logic [9:0]        result_min_cost;
    logic [3:0]        result_match_count;
`ifdef JAM_LOOKUP_CNT_EN
    logic [15:0]       lookup_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Behavioural model: which phase we are in, how many entries have arrived, the result.
    int m_tbl [64];
    bit m_loading;
    bit m_done;
    int m_entries;
    int m_min_cost;
    int m_match_count;
    int m_cnt;

    always #5 CLK = ~CLK;

    jam_cost_server #(.N(N), .COST_W(COST_W)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .reload             (reload),
        .load_valid         (load_valid),
        .load_data          (load_data),
        .load_ready         (load_ready),
        .table_ready        (table_ready),
        .jam_hold           (jam_hold),
        .W                  (W),
        .J                  (J),
        .Cost               (Cost),
        .Valid              (Valid),
        .MinCost            (MinCost),
        .MatchCount         (MatchCount),
        .result_done        (result_done),
        .result_min_cost    (result_min_cost),
        .result_match_count (result_match_count)
`ifdef JAM_LOOKUP_CNT_EN
        ,
        .lookup_cnt         (lookup_cnt)
`endif
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 0;
        m_loading     = 1'b1;
        m_done        = 1'b0;
        m_entries     = 0;
        m_min_cost    = 0;
        m_match_count = 0;
        m_cnt         = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (reload) begin
            m_loading     = 1'b1;
            m_done        = 1'b0;
            m_entries     = 0;
            m_min_cost    = 0;
            m_match_count = 0;
            m_cnt         = 0;
        end else if (m_loading) begin
            if (load_valid) begin
                m_tbl[m_entries] = int'(load_data);
                m_entries++;
                if (m_entries == N * N) begin
                    m_loading = 1'b0;
                    m_entries = 0;
                end
            end
        end else if (!m_done) begin
            if (m_cnt < 65535) m_cnt++;
            if (Valid) begin
                m_done        = 1'b1;
                m_min_cost    = int'(MinCost);
                m_match_count = int'(MatchCount);
            end
        end
    endtask

    task automatic check_output();
        int exp_cost;
        exp_cost = (int'(W) < N && int'(J) < N) ? m_tbl[int'(W) * N + int'(J)] : 0;
        check("load_ready", int'(load_ready), int'(m_loading));
        check("table_ready", int'(table_ready), int'(!m_loading));
        check("jam_hold", int'(jam_hold), int'(m_loading));
        check("cost", int'(Cost), exp_cost);
        check("result_done", int'(result_done), int'(m_done));
        check("result_min_cost", int'(result_min_cost), m_min_cost);
        check("result_match_count", int'(result_match_count), m_match_count);
`ifdef JAM_LOOKUP_CNT_EN
        check("lookup_cnt", int'(lookup_cnt), m_cnt);
`endif
    endtask

    // One clock: drive inputs, check before the edge, update model at the edge.
    task automatic apply_stimulus(input logic rl, input logic lv, input logic [COST_W-1:0] ld,
                                  input logic [2:0] w, input logic [2:0] j, input logic v,
                                  input logic [9:0] mc, input logic [3:0] mcnt);
        reload     = rl;
        load_valid = lv;
        load_data  = ld;
        W          = w;
        J          = j;
        Valid      = v;
        MinCost    = mc;
        MatchCount = mcnt;
        #2;
        check_output();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [2:0] w, input logic [2:0] j);
        apply_stimulus(1'b0, 1'b0, '0, w, j, 1'b0, '0, '0);
    endtask

    task automatic random_step();
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), COST_W'($urandom), 3'($urandom),
                       3'($urandom), 1'b0, 10'($urandom), 4'($urandom));
    endtask

    initial begin
        int guard;
        int ready_cycles;

        RST = 1'b1;
        reload = 1'b0; load_valid = 1'b0; load_data = '0;
        W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0;
        model_reset();
        #3;
        check_output();
        #3;
        RST = 1'b0;

        // Full load with load_valid held high, idx % 100 pattern.
        ready_cycles = 0;
        for (int i = 0; i < 64; i++) begin
            if (load_ready) ready_cycles++;
            apply_stimulus(1'b0, 1'b1, COST_W'(i % 100), 3'd3, 3'd5, 1'b0, '0, '0);
        end
        check("ready_cycles", ready_cycles, 64);
        check("table_ready_after_load", int'(table_ready), 1);
        check("jam_hold_after_load", int'(jam_hold), 0);
        W = 3'd3; J = 3'd5; #1;
        check("cost_w3_j5", int'(Cost), 29);

        for (int i = 0; i < 20; i++) random_step();

        // First result wins.
        apply_stimulus(1'b0, 1'b0, '0, 3'd0, 3'd0, 1'b1, 10'd301, 4'd2);
        apply_stimulus(1'b0, 1'b0, '0, 3'd0, 3'd0, 1'b1, 10'd5, 4'd9);
        check("first_min_cost", int'(result_min_cost), 301);
        check("first_match_count", int'(result_match_count), 2);
        check("first_done", int'(result_done), 1);

        W = 3'd1; J = 3'd1; #1;
        check("old_cost_w1_j1", int'(Cost), 9);
        apply_stimulus(1'b1, 1'b0, '0, 3'd1, 3'd1, 1'b0, '0, '0);
        check("reload_load_ready", int'(load_ready), 1);
        check("reload_jam_hold", int'(jam_hold), 1);
        check("reload_result_done", int'(result_done), 0);
        check("reload_min_cost", int'(result_min_cost), 0);

        // Random-data load with random gaps.
        guard = 0;
        while (m_loading && guard < 400) begin
            random_step();
            guard++;
        end
        check("random_load_finished", int'(m_loading), 0);
        for (int i = 0; i < 10; i++) random_step();

        // Reload collides with Valid: reload wins.
        apply_stimulus(1'b1, 1'b0, '0, 3'd0, 3'd0, 1'b1, 10'd77, 4'd3);
        check("reload_vs_valid_done", int'(result_done), 0);

        // Toggling load_valid, starting low: 128 cycles to SERVE.
        for (int k = 0; k < 128; k++) begin
            apply_stimulus(1'b0, 1'(k % 2), COST_W'((k / 2) % 100), 3'd7, 3'd7, 1'b0, '0, '0);
        end
        check("toggle_table_ready", int'(table_ready), 1);
        W = 3'd7; J = 3'd7; #1;
        check("cost_w7_j7", int'(Cost), 63);
        for (int i = 0; i < 64; i++) idle(3'(i / 8), 3'(i % 8));

        // Counter window: 40 more SERVE cycles, then Valid.
        for (int i = 0; i < 40 - 64; i++) idle(3'd0, 3'd0);
        reload_then_load_fixed();
        for (int i = 0; i < 40; i++) idle(3'($urandom), 3'($urandom));
        apply_stimulus(1'b0, 1'b0, '0, 3'd2, 3'd2, 1'b1, 10'd123, 4'd4);
`ifdef JAM_LOOKUP_CNT_EN
        check("lookup_cnt_41", int'(lookup_cnt), 41);
        for (int i = 0; i < 3; i++) idle(3'd0, 3'd0);
        check("lookup_cnt_frozen", int'(lookup_cnt), 41);
        apply_stimulus(1'b1, 1'b0, '0, 3'd0, 3'd0, 1'b0, '0, '0);
        check("lookup_cnt_reload", int'(lookup_cnt), 0);
`else
        apply_stimulus(1'b1, 1'b0, '0, 3'd0, 3'd0, 1'b0, '0, '0);
`endif

        // Async reset part way through a load clears everything.
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b0, 1'b1, COST_W'($urandom), 3'd0, 3'd0, 1'b0, '0, '0);
        RST = 1'b1;
        #1;
        model_reset();
        check_output();
        check("rst_load_ready", int'(load_ready), 1);
        RST = 1'b0;
        for (int i = 0; i < 64; i++) idle(3'(i / 8), 3'(i % 8));

        // Reload collides with load_valid at idx 10: entry dropped, index restarts.
        for (int i = 0; i < 10; i++)
            apply_stimulus(1'b0, 1'b1, COST_W'($urandom), 3'd1, 3'd2, 1'b0, '0, '0);
        apply_stimulus(1'b1, 1'b1, 7'h55, 3'd1, 3'd2, 1'b0, '0, '0);
        guard = 0;
        while (m_loading && guard < 400) begin
            random_step();
            guard++;
        end
        check("second_load_finished", int'(m_loading), 0);
        for (int i = 0; i < 64; i++) idle(3'(i / 8), 3'(i % 8));
        idle(3'd0, 3'd0);

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Reload and refill with a fixed pattern so the counter window starts from a fresh SERVE entry.
    task automatic reload_then_load_fixed();
        apply_stimulus(1'b1, 1'b0, '0, 3'd0, 3'd0, 1'b0, '0, '0);
        for (int i = 0; i < 64; i++)
            apply_stimulus(1'b0, 1'b1, COST_W'((i * 5 + 3) % 128), 3'd0, 3'd0, 1'b0, '0, '0);
        check("fixed_load_table_ready", int'(table_ready), 1);
    endtask

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder end of the JAM worker/job cost-lookup interface.
- Holds the 8x8 worker-by-job cost table and is loaded through a valid/ready stream.
- Once loaded, returns Cost for the W/J index pair the assignment engine presents, and latches the engine's final MinCost/MatchCount when Valid fires.
- Sits beside the JAM core in the top level and replaces the testbench-side cost ROM.

Parameters:
- N, 8, table dimension (workers = jobs = N); N must be a power of two, at most 8; index ports stay 3 bits.
- COST_W, 7, cost entry width in bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- reload  input  1  single-cycle pulse; restarts table load from any state.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  COST_W  cost entry; row-major order, index = W*N + J.
- load_ready  output  1  high while in LOAD.
- table_ready  output  1  high in SERVE and DONE.
- jam_hold  output  1  holds the JAM core in reset: high in RST or LOAD, low otherwise.
- W  input  3  worker index from the JAM core.
- J  input  3  job index from the JAM core.
- Cost  output  COST_W  table[W*N+J]; combinational read of registered table.
- Valid  input  1  result strobe from the JAM core.
- MinCost  input  10  result from the JAM core.
- MatchCount  input  4  result from the JAM core.
- result_done  output  1  result captured.
- result_min_cost  output  10  captured MinCost.
- result_match_count  output  4  captured MatchCount.

Behaviour:
- States: LOAD, SERVE, DONE. Reset state is LOAD.
- Reset values:
  - load index = 0; table contents = 0.
  - load_ready = 1; table_ready = 0; jam_hold = 1.
  - result_done = 0; result_min_cost = 0; result_match_count = 0.
- LOAD:
  - Each cycle with load_valid && load_ready writes table[idx] = load_data, then idx++.
  - The write of idx = N*N-1 moves to SERVE on the same edge; idx wraps to 0.
  - load_valid low: idx holds; partial loads persist indefinitely.
  - Valid is ignored in LOAD.
- SERVE:
  - Cost = table[W*N+J] in the same cycle (zero latency, as the JAM core samples it).
  - W or J >= N: Cost = 0.
  - Valid = 1: latch MinCost and MatchCount into result_*, set result_done, go to DONE next edge.
  - load_valid is ignored; load_ready = 0.
- DONE:
  - Cost lookups continue to be served.
  - Further Valid pulses are ignored; the first result wins.
  - Remains in DONE until reload or RST.
- reload, in any state:
  - Next state LOAD; idx = 0.
  - result_done = 0 and result_* = 0.
  - Table contents retained until overwritten.
  - jam_hold rises the cycle after the reload edge.
- Simultaneous events:
  - reload with load_valid in LOAD: reload wins and the entry is dropped.
  - reload with Valid in SERVE: reload wins and the result is not captured.
- RST mid-load or mid-serve: everything returns to reset values immediately (async); table cleared.
- Cost does not depend on state; it reads whatever the table holds, including 0 before load.

Optional Feature:
- Macro: JAM_LOOKUP_CNT_EN.
- Defined: adds output lookup_cnt [15:0].
  - Increments once per cycle spent in SERVE.
  - Saturates at 65535.
  - Frozen in DONE.
  - Cleared to 0 by RST and by reload.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Load entries 0..63 with value (idx % 100), load_valid held high -> load_ready high for exactly 64 cycles; table_ready and jam_hold=0 on the cycle after the 64th write; W=3,J=5 gives Cost=29.
- Load with load_valid toggling every other cycle -> 128 cycles to SERVE; W=7,J=7 gives Cost=63; no entries skipped or duplicated.
- In SERVE, drive Valid with MinCost=10'd301, MatchCount=4'd2, then Valid with MinCost=10'd5 -> result_min_cost=301, result_match_count=2, result_done=1, second strobe ignored.
- Pulse reload in DONE -> load_ready=1 and jam_hold=1 next cycle, result_done=0, result_* = 0; before reloading, W=1,J=1 still returns the old value 9.
- Assert RST at load idx 20 -> load_ready=1, idx=0, table reads 0 everywhere; reload in the same cycle as load_valid at idx 10 -> idx=0 and the entry is not written.
- With JAM_LOOKUP_CNT_EN defined: 40 SERVE cycles then Valid -> lookup_cnt=41 (counts the Valid cycle), frozen in DONE, 0 after reload.
